// File: rtl/nexys_starship_damage_gen_pkg.sv
// Shared definitions for the starship damage scheduler.
// Contents: subsystem indices, one-hot state encodings, LFSR feedback mask,
//           and the target-selection helper used in the strike request cycle.
package nexys_starship_damage_gen_pkg;

  // Subsystem indices; these are also the bit positions in the broken vector.
  localparam int SYS_BR = 0;
  localparam int SYS_BL = 1;
  localparam int SYS_TR = 2;
  localparam int SYS_TL = 3;

  // Galois feedback mask (taps 16,14,13,11), applied on a right shift.
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // One-hot encodings so the state bits can drive q_Idle / q_Armed directly.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b01,
    ST_ARMED = 2'b10
  } state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } target_t;

  // First unbroken subsystem scanning start, start+1, ... (mod 4).
  // The loop runs backwards so the smallest offset is the last one written.
  function automatic target_t pick_target(input logic [1:0] start,
                                          input logic [3:0] broken);
    target_t    t;
    logic [1:0] idx;
    t = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (!broken[idx]) begin
        t.found = 1'b1;
        t.idx   = idx;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/nexys_starship_damage_gen_lfsr16.sv
// 16-bit Galois LFSR that free-runs every cycle from reset.
// Ports: Clk, Reset_n (async active-low) in; lfsr[15:0] out (registered).
// A zero state (unreachable in normal use) recovers by reloading SEED.
module nexys_starship_lfsr16
  import nexys_starship_damage_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic [15:0] lfsr
);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr <= SEED;
    end else if (lfsr == 16'h0000) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    end
  end

endmodule

// File: rtl/nexys_starship_damage_gen.sv
// Damage scheduler: periodically strikes one unbroken subsystem with a fresh repair code.
// Ports: Clk, Reset_n, play_flag, gameover_ctrl, broken[3:0] in;
//        TL/TR/BL/BR_random, random_hex[3:0], level[3:0], q_Idle, q_Armed out (all registered).
module nexys_starship_damage_gen
  import nexys_starship_damage_gen_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 100_000_000,
  parameter int unsigned BASE_INTERVAL = 8,
  parameter int unsigned MIN_INTERVAL  = 2,
  parameter int unsigned LEVEL_STEP    = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       play_flag,
  input  logic       gameover_ctrl,
  input  logic [3:0] broken,
  output logic       TL_random,
  output logic       TR_random,
  output logic       BL_random,
  output logic       BR_random,
  output logic [3:0] random_hex,
  output logic [3:0] level,
  output logic       q_Idle,
  output logic       q_Armed
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  state_t      state;
  logic [PW-1:0] prescaler;
  logic [3:0]  interval_cnt;
  logic [7:0]  strike_cnt;
  logic [3:0]  strike;        // {TL,TR,BL,BR}
  logic [3:0]  cur_interval;
  logic [15:0] lfsr;
  logic        lfsr_unused;
  logic        tick;
  logic        request;
  logic        abort;
  target_t     tgt;

  nexys_starship_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .lfsr    (lfsr)
  );

  assign lfsr_unused = ^{lfsr[15:8], lfsr[3:2]};

  // Interval shrinks by one tick per level, floored at MIN_INTERVAL.
  always_comb begin
    cur_interval = 4'(BASE_INTERVAL) - level;
    if (({1'b0, level} + 5'(MIN_INTERVAL)) >= 5'(BASE_INTERVAL)) begin
      cur_interval = 4'(MIN_INTERVAL);
    end
  end

  assign tick    = (prescaler == PRE_MAX);
  assign request = tick && (interval_cnt <= 4'd1);
  assign abort   = gameover_ctrl || !play_flag;
  assign tgt     = pick_target(lfsr[1:0], broken);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= ST_IDLE;
      prescaler    <= '0;
      interval_cnt <= '0;
      strike_cnt   <= '0;
      level        <= '0;
      strike       <= '0;
      random_hex   <= '0;
    end else begin
      strike <= '0;
      case (state)
        ST_IDLE: begin
          prescaler    <= '0;
          strike_cnt   <= '0;
          level        <= '0;
          interval_cnt <= 4'(BASE_INTERVAL);
          if (play_flag && !gameover_ctrl) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (abort) begin
            // Leaving wins over any strike requested this cycle.
            state      <= ST_IDLE;
            prescaler  <= '0;
            strike_cnt <= '0;
            level      <= '0;
          end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (request) begin
              // Reload uses the level as it stands now; a level change
              // made by this strike applies from the following reload.
              interval_cnt <= cur_interval;
              if (tgt.found) begin
                strike     <= 4'b0001 << tgt.idx;
                random_hex <= lfsr[7:4];
                if (strike_cnt + 8'd1 >= 8'(LEVEL_STEP)) begin
                  strike_cnt <= '0;
                  if (level != 4'hF) level <= level + 4'd1;
                end else begin
                  strike_cnt <= strike_cnt + 8'd1;
                end
              end
            end else if (tick) begin
              interval_cnt <= interval_cnt - 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign TL_random = strike[SYS_TL];
  assign TR_random = strike[SYS_TR];
  assign BL_random = strike[SYS_BL];
  assign BR_random = strike[SYS_BR];
  assign q_Idle    = state[0];
  assign q_Armed   = state[1];

endmodule

// File: tb/tb_nexys_starship_damage_gen.sv
// Directed bench for nexys_starship_damage_gen with a short tick.
// Strike gaps, targets and repair codes are predicted from a reference LFSR.
// Outputs are sampled on the falling edge.
module tb_nexys_starship_damage_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       play_flag = 1'b0;
  logic       gameover_ctrl = 1'b0;
  logic [3:0] broken = 4'h0;
  logic       TL_random, TR_random, BL_random, BR_random;
  logic [3:0] random_hex, level;
  logic       q_Idle, q_Armed;

  nexys_starship_damage_gen #(
    .TICK_DIV      (4),
    .BASE_INTERVAL (3),
    .MIN_INTERVAL  (2),
    .LEVEL_STEP    (2),
    .LFSR_SEED     (SEED)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .play_flag     (play_flag),
    .gameover_ctrl (gameover_ctrl),
    .broken        (broken),
    .TL_random     (TL_random),
    .TR_random     (TR_random),
    .BL_random     (BL_random),
    .BR_random     (BR_random),
    .random_hex    (random_hex),
    .level         (level),
    .q_Idle        (q_Idle),
    .q_Armed       (q_Armed)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference LFSR; m_prev holds the value seen during the previous cycle,
  // i.e. the request cycle when a strike is visible.
  logic [15:0] m_lfsr, m_prev;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_lfsr <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_lfsr;
      if (m_lfsr == 16'h0) m_lfsr <= SEED;
      else m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  logic [3:0] pulses;
  assign pulses = {TL_random, TR_random, BL_random, BR_random};

  function automatic int exp_target(input logic [1:0] start, input logic [3:0] brk);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (int'(start) + k) % 4;
      if (!brk[idx]) return idx;
    end
    return -1;
  endfunction

  // Steps falling edges until a strike appears; checks its shape and contents.
  task automatic wait_strike(input int budget, output int gap);
    bit found;
    int t;
    gap   = 0;
    found = 1'b0;
    while (!found && gap < budget) begin
      @(negedge Clk);
      gap++;
      if (pulses != 4'h0) found = 1'b1;
    end
    if (!found) begin
      chk("strike_timeout", 32'd0, 32'd1);
    end else begin
      t = exp_target(m_prev[1:0], broken);
      chk("strike_onehot", $countones(pulses), 32'd1);
      if (t >= 0) chk("strike_target", {28'h0, pulses}, 32'd1 << t);
      else chk("strike_unexpected", {28'h0, pulses}, 32'd0);
      chk("strike_hex", {28'h0, random_hex}, {28'h0, m_prev[7:4]});
    end
  endtask

  int gap;
  int cnt;
  logic [3:0] hold_hex;

  initial begin
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    // Idle with play low: nothing fires.
    cnt = 0;
    repeat (50) begin
      @(negedge Clk);
      if (pulses != 4'h0) cnt++;
    end
    chk("idle_pulses", cnt, 0);
    chk("idle_hex", {28'h0, random_hex}, 32'd0);
    chk("idle_q_idle", {31'h0, q_Idle}, 32'd1);
    chk("idle_q_armed", {31'h0, q_Armed}, 32'd0);
    chk("idle_level", {28'h0, level}, 32'd0);

    // Arm; first strike 12 cycles after q_Armed rises.
    play_flag = 1'b1;
    @(negedge Clk);
    chk("armed", {31'h0, q_Armed}, 32'd1);
    wait_strike(40, gap); chk("gap1", gap, 12); chk("lvl1", {28'h0, level}, 32'd0);
    wait_strike(40, gap); chk("gap2", gap, 12); chk("lvl2", {28'h0, level}, 32'd1);
    wait_strike(40, gap); chk("gap3", gap, 12); chk("lvl3", {28'h0, level}, 32'd1);
    wait_strike(40, gap); chk("gap4", gap, 8);  chk("lvl4", {28'h0, level}, 32'd2);
    wait_strike(40, gap); chk("gap5", gap, 8);  chk("lvl5", {28'h0, level}, 32'd2);

    // Only BR unbroken: every strike must land there.
    broken = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      wait_strike(40, gap);
      chk("br_gap", gap, 8);
      chk("br_only", {31'h0, BR_random}, 32'd1);
    end

    // Everything broken: no pulses, code held over 5 intervals.
    broken   = 4'hF;
    hold_hex = random_hex;
    cnt      = 0;
    repeat (44) begin
      @(negedge Clk);
      if (pulses != 4'h0) cnt++;
    end
    chk("allbroken_pulses", cnt, 0);
    chk("allbroken_hex", {28'h0, random_hex}, {28'h0, hold_hex});

    // Game over asserted in the request cycle drops the strike.
    broken = 4'h0;
    wait_strike(40, gap);
    repeat (7) @(negedge Clk);
    gameover_ctrl = 1'b1;
    @(negedge Clk);
    chk("go_drop", {28'h0, pulses}, 32'd0);
    chk("go_idle", {31'h0, q_Idle}, 32'd1);
    chk("go_level", {28'h0, level}, 32'd0);
    cnt = 0;
    repeat (20) begin
      @(negedge Clk);
      if (pulses != 4'h0 || !q_Idle) cnt++;
    end
    chk("go_hold_idle", cnt, 0);

    // Reset mid-interval.
    gameover_ctrl = 1'b0;
    @(negedge Clk);
    chk("rearm", {31'h0, q_Armed}, 32'd1);
    repeat (5) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("rst_mid_idle", {31'h0, q_Idle}, 32'd1);
    chk("rst_mid_armed", {31'h0, q_Armed}, 32'd0);
    chk("rst_mid_hex", {28'h0, random_hex}, 32'd0);
    chk("rst_mid_level", {28'h0, level}, 32'd0);

    // Reset during a strike cycle.
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("rearm2", {31'h0, q_Armed}, 32'd1);
    wait_strike(40, gap);
    chk("gap_after_rst", gap, 12);
    Reset_n = 1'b0;
    #1;
    chk("rst_pulse_drop", {28'h0, pulses}, 32'd0);
    chk("rst_pulse_hex", {28'h0, random_hex}, 32'd0);
    chk("rst_pulse_idle", {31'h0, q_Idle}, 32'd1);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
